// File: rtl/framebuffer_readback_engine.sv
// Streams a run of framebuffer pixels to a UART transmitter, one byte per pixel,
// optionally preceded by a FRAME header byte so the capture can be replayed.
module framebuffer_readback_engine #(
  parameter int         BITS_PER_PIXEL    = 3,
  parameter int         FRAMEBUFFER_DEPTH = 640*480,
  parameter bit         SEND_HEADER       = 1'b1,
  parameter logic [7:0] HEADER_BYTE       = 8'h04
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_N,
  input  logic                      i_Start,
  input  logic [31:0]               i_Start_Addr,
  input  logic [31:0]               i_Pixel_Count,
  output logic                      o_Busy,
  output logic                      o_Done,
  output logic                      o_Read_Enable,
  output logic [31:0]               o_Read_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Read_Data,
  output logic                      o_Tx_DV,
  output logic [7:0]                o_Tx_Byte,
  input  logic                      i_Tx_Done
);

  typedef enum logic [3:0] {
    S_IDLE, S_HEADER, S_WAIT_HDR, S_CHECK, S_READ,
    S_CAPTURE, S_SEND, S_WAIT_TX, S_FINISH
  } state_t;

  localparam logic [31:0] LAST_ADDR = 32'(FRAMEBUFFER_DEPTH - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, remaining_q, read_addr_q;
  logic [7:0]  tx_byte_q;

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (i_Start) state_d = SEND_HEADER ? S_HEADER : S_CHECK;
      S_HEADER:   state_d = S_WAIT_HDR;
      S_WAIT_HDR: if (i_Tx_Done) state_d = S_CHECK;
      S_CHECK:    state_d = (remaining_q == 32'd0) ? S_FINISH : S_READ;
      S_READ:     state_d = S_CAPTURE;
      S_CAPTURE:  state_d = S_SEND;
      S_SEND:     state_d = S_WAIT_TX;
      S_WAIT_TX:  if (i_Tx_Done) state_d = S_CHECK;
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Read address and TX byte are registered so they hold between strobes.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      addr_q      <= '0;
      remaining_q <= '0;
      read_addr_q <= '0;
      tx_byte_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_Start) begin
          addr_q      <= i_Start_Addr;
          remaining_q <= i_Pixel_Count;
          if (SEND_HEADER) tx_byte_q <= HEADER_BYTE;
        end
        S_CHECK: if (remaining_q != 32'd0) read_addr_q <= addr_q;
        S_CAPTURE: begin
          tx_byte_q <= 8'(i_Read_Data);
          addr_q    <= (addr_q == LAST_ADDR) ? 32'd0 : addr_q + 32'd1;
          if (remaining_q != 32'd0) remaining_q <= remaining_q - 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_Busy        = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign o_Done        = (state_q == S_FINISH);
  assign o_Read_Enable = (state_q == S_READ);
  assign o_Read_Addr   = read_addr_q;
  assign o_Tx_DV       = (state_q == S_HEADER) || (state_q == S_SEND);
  assign o_Tx_Byte     = tx_byte_q;

endmodule

// File: tb/tb_framebuffer_readback_engine.sv
// Directed bench: instance 0 sends a header, instance 1 does not; both use a
// 16-entry framebuffer model and a UART TX model with programmable ack delay.
module tb_framebuffer_readback_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic        start [2];
  logic [31:0] saddr [2], cnt [2], raddr [2];
  logic        busy [2], done [2], re [2], dv [2], txd [2], txauto [2], txman [2];
  logic [2:0]  rdata [2];
  logic [7:0]  txb [2];
  int          dly [2], txc [2], nb [2], na [2], dn [2];
  logic [7:0]  bytes [2][64];
  logic [31:0] addrs [2][64];
  logic [2:0]  mem [16];
  int checks = 0, errors = 0;

  assign txd[0] = txauto[0] | txman[0];
  assign txd[1] = txauto[1] | txman[1];

  framebuffer_readback_engine #(.BITS_PER_PIXEL(3), .FRAMEBUFFER_DEPTH(16),
    .SEND_HEADER(1'b1), .HEADER_BYTE(8'h04)) u_a (
    .i_Clock(clk), .i_Reset_N(rst_n), .i_Start(start[0]), .i_Start_Addr(saddr[0]),
    .i_Pixel_Count(cnt[0]), .o_Busy(busy[0]), .o_Done(done[0]), .o_Read_Enable(re[0]),
    .o_Read_Addr(raddr[0]), .i_Read_Data(rdata[0]), .o_Tx_DV(dv[0]), .o_Tx_Byte(txb[0]),
    .i_Tx_Done(txd[0]));

  framebuffer_readback_engine #(.BITS_PER_PIXEL(3), .FRAMEBUFFER_DEPTH(16),
    .SEND_HEADER(1'b0), .HEADER_BYTE(8'h04)) u_b (
    .i_Clock(clk), .i_Reset_N(rst_n), .i_Start(start[1]), .i_Start_Addr(saddr[1]),
    .i_Pixel_Count(cnt[1]), .o_Busy(busy[1]), .o_Done(done[1]), .o_Read_Enable(re[1]),
    .o_Read_Addr(raddr[1]), .i_Read_Data(rdata[1]), .o_Tx_DV(dv[1]), .o_Tx_Byte(txb[1]),
    .i_Tx_Done(txd[1]));

  // Framebuffer: data returned one cycle after the read strobe.
  always @(posedge clk)
    for (int g = 0; g < 2; g++) if (re[g]) rdata[g] <= mem[raddr[g][3:0]];

  // UART TX model (auto ack dly cycles after DV when dly > 0) and stream monitor.
  always @(negedge clk)
    for (int g = 0; g < 2; g++) begin
      txauto[g] = 1'b0;
      if (txc[g] > 0) begin txc[g]--; if (txc[g] == 0) txauto[g] = 1'b1; end
      if (dv[g] && dly[g] > 0) txc[g] = dly[g];
      if (dv[g] && nb[g] < 64) begin bytes[g][nb[g]] = txb[g]; nb[g]++; end
      if (re[g] && na[g] < 64) begin addrs[g][na[g]] = raddr[g]; na[g]++; end
      if (done[g]) dn[g]++;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr(input int s, input int d);
    @(negedge clk); #1;
    dly[s] = d; nb[s] = 0; na[s] = 0; dn[s] = 0;
  endtask

  task automatic run(input int s, input logic [31:0] ad, input logic [31:0] n, input int d);
    clr(s, d);
    saddr[s] = ad; cnt[s] = n; start[s] = 1'b1;
    @(negedge clk); start[s] = 1'b0;
    for (int i = 0; i < 3000 && dn[s] == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1 chk("done_seen", 32'(dn[s] > 0), 32'd1);
  endtask

  task automatic wait_dv(input int s);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dv[s]) break;
    end
    chk("dv_seen", 32'(dv[s]), 32'd1);
  endtask

  typedef struct {
    logic [31:0] ad, n;
    int          d, nb, na;
    logic [7:0]  b [6];
    logic [31:0] a [5];
  } vec_t;
  vec_t v [4];

  initial begin
    mem = '{3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3, 3'd0, 3'd7,
            3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd3, 3'd5, 3'd7};
    for (int g = 0; g < 2; g++) begin
      start[g] = 0; saddr[g] = 0; cnt[g] = 0; txman[g] = 0; txauto[g] = 0;
      rdata[g] = 0; dly[g] = 0; txc[g] = 0; nb[g] = 0; na[g] = 0; dn[g] = 0;
    end
    v[0].ad = 10; v[0].n = 3; v[0].d = 5; v[0].nb = 4; v[0].na = 3;
    v[0].b = '{8'h04, 8'h04, 8'h02, 8'h01, 8'h00, 8'h00}; v[0].a = '{10, 11, 12, 0, 0};
    v[1].ad = 14; v[1].n = 4; v[1].d = 1; v[1].nb = 5; v[1].na = 4;
    v[1].b = '{8'h04, 8'h05, 8'h07, 8'h05, 8'h06, 8'h00}; v[1].a = '{14, 15, 0, 1, 0};
    v[2].ad = 0; v[2].n = 0; v[2].d = 2; v[2].nb = 1; v[2].na = 0;
    v[2].b = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; v[2].a = '{0, 0, 0, 0, 0};
    v[3].ad = 3; v[3].n = 2; v[3].d = 3; v[3].nb = 3; v[3].na = 2;
    v[3].b = '{8'h04, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00}; v[3].a = '{3, 4, 0, 0, 0};

    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_ctl", {28'd0, busy[g], done[g], re[g], dv[g]}, 32'd0);
      chk("rst_addr", raddr[g], 32'd0);
      chk("rst_byte", 32'(txb[g]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Header-mode transfers from the vector table.
    for (int i = 0; i < 4; i++) begin
      run(0, v[i].ad, v[i].n, v[i].d);
      chk($sformatf("v%0d_nbytes", i), 32'(nb[0]), 32'(v[i].nb));
      for (int j = 0; j < v[i].nb; j++)
        chk($sformatf("v%0d_byte%0d", i, j), 32'(bytes[0][j]), 32'(v[i].b[j]));
      chk($sformatf("v%0d_nreads", i), 32'(na[0]), 32'(v[i].na));
      for (int j = 0; j < v[i].na; j++)
        chk($sformatf("v%0d_addr%0d", i, j), addrs[0][j], v[i].a[j]);
      chk($sformatf("v%0d_ndone", i), 32'(dn[0]), 32'd1);
      chk($sformatf("v%0d_idle", i), 32'(busy[0]), 32'd0);
    end

    // Zero count without header: CHECK at T+1, FINISH at T+2.
    clr(1, 1);
    saddr[1] = 5; cnt[1] = 0; start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    chk("zc_busy_t1", {30'd0, busy[1], done[1]}, 32'h2);
    @(negedge clk);
    chk("zc_done_t2", {30'd0, busy[1], done[1]}, 32'h1);
    @(negedge clk);
    chk("zc_after", {30'd0, busy[1], done[1]}, 32'h0);
    #1 chk("zc_nodv", 32'(nb[1]), 32'd0);
    chk("zc_noread", 32'(na[1]), 32'd0);

    // Full frame without header: stream equals framebuffer contents.
    run(1, 0, 16, 2);
    chk("ff_nbytes", 32'(nb[1]), 32'd16);
    for (int j = 0; j < 16; j++) chk($sformatf("ff_byte%0d", j), 32'(bytes[1][j]), 32'(mem[j]));

    // Count larger than depth: addresses wrap and pixels repeat.
    run(1, 15, 18, 1);
    chk("ov_nreads", 32'(na[1]), 32'd18);
    chk("ov_addr0", addrs[1][0], 32'd15);
    chk("ov_addr1", addrs[1][1], 32'd0);
    chk("ov_addr17", addrs[1][17], 32'd0);
    chk("ov_byte17", 32'(bytes[1][17]), 32'h05);

    // Fastest TX ack and an ignored start during WAIT_TX.
    clr(0, 0);
    saddr[0] = 10; cnt[0] = 2; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    chk("hdr_latency", {23'd0, dv[0], txb[0]}, {23'd0, 1'b1, 8'h04});
    @(negedge clk); txman[0] = 1'b1;
    @(negedge clk); txman[0] = 1'b0;
    wait_dv(0);
    @(negedge clk); txman[0] = 1'b1;
    @(negedge clk); txman[0] = 1'b0;
    chk("fast_check_cycle", 32'(re[0]), 32'd0);
    @(negedge clk);
    chk("fast_read_cycle", 32'(re[0]), 32'd1);
    chk("fast_read_addr", raddr[0], 32'd11);
    wait_dv(0);
    @(negedge clk); start[0] = 1'b1; saddr[0] = 0; cnt[0] = 5;
    @(negedge clk); start[0] = 1'b0; txman[0] = 1'b1;
    @(negedge clk); txman[0] = 1'b0;
    repeat (12) @(negedge clk);
    #1 chk("bs_nbytes", 32'(nb[0]), 32'd3);
    chk("bs_byte2", 32'(bytes[0][2]), 32'h02);
    chk("bs_ndone", 32'(dn[0]), 32'd1);
    chk("bs_idle", 32'(busy[0]), 32'd0);

    // Reset while waiting on the UART; a late ack must not revive anything.
    clr(0, 0);
    saddr[0] = 0; cnt[0] = 4; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    @(negedge clk); txman[0] = 1'b1;
    @(negedge clk); txman[0] = 1'b0;
    wait_dv(0);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("mr_ctl", {28'd0, busy[0], done[0], re[0], dv[0]}, 32'd0);
    chk("mr_addr", raddr[0], 32'd0);
    chk("mr_byte", 32'(txb[0]), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); txman[0] = 1'b1;
    @(negedge clk); txman[0] = 1'b0;
    repeat (20) @(negedge clk);
    #1 chk("mr_nodone", 32'(dn[0]), 32'd0);
    chk("mr_nbytes", 32'(nb[0]), 32'd2);
    chk("mr_idle", 32'(busy[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/framebuffer_readback_engine.md
Name: framebuffer_readback_engine

Overview:
- Read-side counterpart to the UART instruction engine.
- On a start pulse, reads a run of pixels from the framebuffer read port and serialises them to the UART transmitter, one byte per pixel.
- The stream is preceded by an optional header byte, so a captured stream can be replayed into the instruction engine as a FRAME command.
- Sits between the framebuffer (read port) and the UART TX module; used for readback/debug and loopback verification.

Parameters:
BITS_PER_PIXEL, 3, pixel width; legal range 1..8.
FRAMEBUFFER_DEPTH, 640*480, number of pixel addresses; reads wrap modulo this value.
SEND_HEADER, 1, 1 = emit HEADER_BYTE before pixel data; 0 = pixel data only.
HEADER_BYTE, 8'h04, header value (FRAME opcode).

Ports:
i_Clock  in  1  system clock.
i_Reset_N  in  1  asynchronous active-low reset.
i_Start  in  1  one-cycle start request; honoured only in IDLE.
i_Start_Addr  in  32  first pixel address; must be < FRAMEBUFFER_DEPTH.
i_Pixel_Count  in  32  number of pixels to send.
o_Busy  out  1  high from the cycle after start is accepted until done.
o_Done  out  1  one-cycle pulse at completion.
o_Read_Enable  out  1  framebuffer read strobe.
o_Read_Addr  out  32  framebuffer read address.
i_Read_Data  in  BITS_PER_PIXEL  read data, valid exactly 1 cycle after o_Read_Enable.
o_Tx_DV  out  1  one-cycle byte-valid to UART TX.
o_Tx_Byte  out  8  byte to transmit; held stable until the matching i_Tx_Done.
i_Tx_Done  in  1  one-cycle pulse from UART TX when the byte's stop bit completes.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; o_Busy, o_Done, o_Read_Enable, o_Tx_DV = 0; o_Read_Addr = 0; o_Tx_Byte = 0; internal counters = 0.
- Reset mid-transfer aborts with no o_Done pulse. A byte already handed to UART TX may still complete; its i_Tx_Done arriving in IDLE is ignored.
- States:
  - IDLE: on i_Start, latch i_Start_Addr into addr and i_Pixel_Count into remaining. Next state = HEADER if SEND_HEADER, else CHECK.
  - HEADER: o_Tx_Byte = HEADER_BYTE, o_Tx_DV = 1 for this single cycle. Next = WAIT_HDR.
  - WAIT_HDR: wait for i_Tx_Done, then go to CHECK.
  - CHECK: if remaining == 0, go to FINISH; else go to READ.
  - READ: o_Read_Enable = 1, o_Read_Addr = addr, for one cycle. Next = CAPTURE.
  - CAPTURE: o_Tx_Byte = zero-extended i_Read_Data. Update addr = (addr == FRAMEBUFFER_DEPTH-1) ? 0 : addr+1. Decrement remaining. Next = SEND.
  - SEND: o_Tx_DV = 1 for one cycle. Next = WAIT_TX.
  - WAIT_TX: wait for i_Tx_Done, then go to CHECK.
  - FINISH: o_Done = 1 for one cycle. Next = IDLE.
- o_Busy is high in every state except IDLE and FINISH. It therefore falls in the same cycle o_Done rises.
- i_Tx_Done may arrive as early as the cycle after o_Tx_DV; it must be accepted there. i_Tx_Done outside WAIT_HDR/WAIT_TX is ignored.
- i_Start while not in IDLE is ignored; there is no queuing. i_Start_Addr and i_Pixel_Count are sampled only at acceptance.
- Latency from i_Start (cycle T):
  - with SEND_HEADER=1: o_Tx_DV for the header at T+1.
  - with SEND_HEADER=0: first o_Read_Enable at T+2 (T+1 is CHECK).
- Per-pixel cost: 4 cycles plus UART wait.
- i_Pixel_Count == 0: header only (if enabled), then o_Done. With SEND_HEADER=0, o_Done occurs at T+2.
- i_Pixel_Count > FRAMEBUFFER_DEPTH is legal: addresses wrap and pixels are resent.
- o_Read_Addr holds its last value when o_Read_Enable is low. o_Tx_Byte holds until the next CAPTURE/HEADER.
- Counters are 32-bit and never underflow: decrement happens only when remaining != 0.

Test Plan:
1. Reset mid-stream: assert i_Reset_N=0 during WAIT_TX → all outputs 0 immediately. After release, a late i_Tx_Done has no effect and o_Done never pulses.
2. Header plus 3 pixels: SEND_HEADER=1, start addr 10, count 3, memory[10..12] = 3'b100, 3'b010, 3'b001, TX model returns i_Tx_Done 5 cycles after each DV → bytes 0x04, 0x04, 0x02, 0x01. Read addresses 10, 11, 12. Exactly one o_Done.
3. Wrap-around: FRAMEBUFFER_DEPTH=16, start addr 14, count 4 → read addresses 14, 15, 0, 1.
4. Zero count: SEND_HEADER=0, count 0 → no o_Tx_DV, no o_Read_Enable, o_Done at T+2, o_Busy high only at T+1.
5. Busy start plus fastest TX: i_Start pulsed during WAIT_TX is ignored (byte count unchanged). i_Tx_Done returned the cycle right after o_Tx_DV → next o_Read_Enable 2 cycles later (CHECK, READ).
6. Loopback: drive the output byte stream (full frame, depth 16) into the instruction engine → written framebuffer contents equal the source contents.
